// File: rtl/sr_drive_sequencer_if.sv
// Target handshake, flop feedback and drive/status signals of one SR drive sequencer.
interface sr_drive_sequencer_if #(
    parameter int N = 4
);
    logic         tgt_valid;
    logic [N-1:0] tgt_data;
    logic         tgt_ready;
    logic [N-1:0] q_fb;
    logic [N-1:0] S;
    logic [N-1:0] R;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, S, R, busy, done, err
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, S, R, busy, done, err
    );
endinterface

// File: rtl/sr_drive_sequencer.sv
// Drives N SR flops toward a target word: pulse S/R for PULSE cycles, then
// watch the fed-back Q until it matches or TIMEOUT mismatching cycles elapse.
module sr_drive_sequencer #(
    parameter int N       = 4,
    parameter int PULSE   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_drive_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [3:0] PULSE_M1 = 4'(PULSE - 1);
    localparam logic [7:0] TMO_M1   = 8'(TIMEOUT - 1);

    state_t       state, state_d;
    logic [N-1:0] tgt_q, tgt_d;
    logic [N-1:0] s_q, s_d, r_q, r_d;
    logic [3:0]   pcnt_q, pcnt_d;
    logic [7:0]   tcnt_q, tcnt_d;
    logic         done_q, done_d, err_q, err_d;
    logic         accept;
    logic [N-1:0] exc_s, exc_r;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Excitation is disjoint by construction, so S and R never overlap on a bit.
    assign accept = bus.tgt_valid && (state == IDLE);
    assign exc_s  = bus.tgt_data & ~bus.q_fb;
    assign exc_r  = ~bus.tgt_data & bus.q_fb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tgt_q  <= '0;
            s_q    <= '0;
            r_q    <= '0;
            pcnt_q <= '0;
            tcnt_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            tgt_q  <= tgt_d;
            s_q    <= s_d;
            r_q    <= r_d;
            pcnt_q <= pcnt_d;
            tcnt_q <= tcnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        tgt_d   = tgt_q;
        s_d     = s_q;
        r_d     = r_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    tgt_d  = bus.tgt_data;
                    pcnt_d = '0;
                    tcnt_d = '0;
                    if ((exc_s | exc_r) == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        s_d     = exc_s;
                        r_d     = exc_r;
                    end
                end
            end
            DRIVE: begin
                if (pcnt_q == PULSE_M1) begin
                    state_d = CHECK;
                    s_d     = '0;
                    r_d     = '0;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            CHECK: begin
                // A match on the same edge as the final mismatch slot wins.
                if (bus.q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = sat_inc8(tcnt_q);
                    if (tcnt_q == TMO_M1) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                r_d     = '0;
            end
        endcase
    end

    assign bus.tgt_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.S         = s_q;
    assign bus.R         = r_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Directed bench for sr_drive_sequencer with N=4, PULSE=2, TIMEOUT=8.
module tb_sr_drive_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sr_drive_sequencer_if #(.N(4)) bus ();

    sr_drive_sequencer #(.N(4), .PULSE(2), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] s, input logic [3:0] r,
                        input logic bsy, input logic dn, input logic er);
        chk({tag, ".S"},     32'(bus.S), 32'(s));
        chk({tag, ".R"},     32'(bus.R), 32'(r));
        chk({tag, ".SandR"}, 32'(bus.S & bus.R), 32'd0);
        chk({tag, ".busy"},  32'(bus.busy), 32'(bsy));
        chk({tag, ".ready"}, 32'(bus.tgt_ready), 32'(!bsy));
        chk({tag, ".done"},  32'(bus.done), 32'(dn));
        chk({tag, ".err"},   32'(bus.err), 32'(er));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = 4'b0000;
        bus.q_fb      = 4'b0000;
        #3;
        outs("rst_async", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        outs("idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Set two bits from all-zero.
        bus.q_fb      = 4'b0000;
        bus.tgt_data  = 4'b1010;
        bus.tgt_valid = 1'b1;
        step();
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = 4'b0101;
        outs("set.d1", 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0);
        bus.q_fb = 4'b1010;
        step();
        outs("set.d2", 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        outs("set.chk", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        outs("set.done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

        // Mixed set/reset, accepted in the same cycle done is high.
        bus.q_fb      = 4'b1100;
        bus.tgt_data  = 4'b0110;
        bus.tgt_valid = 1'b1;
        step();
        bus.tgt_valid = 1'b0;
        outs("mix.d1", 4'b0010, 4'b1000, 1'b1, 1'b0, 1'b0);
        step();
        outs("mix.d2", 4'b0010, 4'b1000, 1'b1, 1'b0, 1'b0);
        step();
        outs("mix.chk1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        bus.q_fb = 4'b0110;
        step();
        outs("mix.done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        outs("mix.after", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Already at target: no drive, immediate done.
        bus.q_fb      = 4'b0101;
        bus.tgt_data  = 4'b0101;
        bus.tgt_valid = 1'b1;
        step();
        bus.tgt_valid = 1'b0;
        outs("hold.done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        outs("hold.after", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Stuck feedback: eight mismatching CHECK cycles then err.
        bus.q_fb      = 4'b0000;
        bus.tgt_data  = 4'b1111;
        bus.tgt_valid = 1'b1;
        step();
        bus.tgt_valid = 1'b0;
        outs("tmo.d1", 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        outs("tmo.d2", 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            outs($sformatf("tmo.chk%0d", i), 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        end
        step();
        outs("tmo.err", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        outs("tmo.after", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset during the second DRIVE cycle aborts silently.
        bus.q_fb      = 4'b0110;
        bus.tgt_data  = 4'b0011;
        bus.tgt_valid = 1'b1;
        step();
        bus.tgt_valid = 1'b0;
        outs("ab.d1", 4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0);
        step();
        outs("ab.d2", 4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        outs("ab.rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            outs($sformatf("ab.hold%0d", i), 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        rst_n         = 1'b1;
        bus.q_fb      = 4'b0000;
        bus.tgt_data  = 4'b0001;
        bus.tgt_valid = 1'b1;
        step();
        bus.tgt_valid = 1'b0;
        outs("ab.reacc", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        bus.q_fb = 4'b0001;
        step();
        step();
        outs("ab.chk", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        outs("ab.done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sr_drive_sequencer.md
SR_DRIVE_SEQUENCER -- requirements
Module: sr_drive_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: number of SR flip-flops driven in parallel.
REQ-002 SHALL have parameter PULSE, default 2: cycles S/R held active per update (legal 1..15).
REQ-003 SHALL have parameter TIMEOUT, default 8: CHECK cycles allowed before error (legal 1..255).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port tgt_valid, input, 1: target word offered.
REQ-007 SHALL have port tgt_data, input, N: desired Q value for each flop.
REQ-008 SHALL have port tgt_ready, output, 1: sequencer can accept a target.
REQ-009 SHALL have port q_fb, input, N: Q outputs fed back from the driven flops.
REQ-010 SHALL have port S, output, N: registered set drive, one bit per flop.
REQ-011 SHALL have port R, output, N: registered reset drive, one bit per flop.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when flops reach target.
REQ-014 SHALL have port err, output, 1: one-cycle pulse on timeout.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, CHECK; tgt_ready = (state == IDLE), combinational from state only.
REQ-016 Accept occurs on a rising edge with tgt_valid & tgt_ready; tgt_data SHALL be captured into an internal target register.
REQ-017 At accept, excitation SHALL be computed from q_fb sampled at that edge: S = tgt_data & ~q_fb, R = ~tgt_data & q_fb (SR excitation table; per-bit hold = 00).
REQ-018 If excitation is all-zero at accept, the FSM SHALL stay in IDLE, S/R stay 0, and done SHALL pulse in the next cycle.
REQ-019 Otherwise the FSM SHALL enter DRIVE, with S/R presenting the excitation starting the cycle after the accept edge.
REQ-020 S/R SHALL remain constant for exactly PULSE cycles, then the FSM SHALL enter CHECK with S = R = 0.
REQ-021 S & R SHALL be all-zero in every cycle, including reset and transitions; 2'b11 per bit is never driven.
REQ-022 In CHECK, each edge SHALL compare q_fb to the target; on match, done SHALL pulse in the following cycle and the FSM SHALL return to IDLE.
REQ-023 In CHECK, a 8-bit counter SHALL count mismatching edges; on the TIMEOUT-th mismatch, err SHALL pulse in the following cycle and the FSM SHALL return to IDLE.
REQ-024 Match SHALL take priority over timeout on the same edge.
REQ-025 done and err SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per operation.
REQ-026 Back-to-back operation SHALL be allowed: a new accept may occur in the same cycle that done or err is high.
REQ-027 tgt_valid and tgt_data SHALL be ignored while busy; q_fb changes during DRIVE SHALL not alter S/R.
REQ-028 The pulse counter and the timeout counter SHALL clear on every accept.

Reset
REQ-029 While rst_n = 0, asynchronously and regardless of clk: state = IDLE; S = R = 0; done = err = busy = 0; target register and counters SHALL be 0.
REQ-030 Reset asserted mid-DRIVE or mid-CHECK SHALL abort the operation with no done or err pulse; the first accept SHALL be possible on the first rising edge after rst_n rises.

Verification (N=4, PULSE=2, TIMEOUT=8)
REQ-031 Reset then idle: S=R=0000, tgt_ready=1, busy=0, done=err=0.
REQ-032 q_fb=0000, accept tgt_data=1010: S=1010/R=0000 for 2 cycles, then 0000; model flops set q_fb=1010; CHECK matches, done pulses once, tgt_ready returns to 1.
REQ-033 q_fb=1100, accept tgt_data=0110: S=0010, R=1000 for 2 cycles; no bit has S=R=1; done pulses after q_fb=0110.
REQ-034 q_fb=0101, accept tgt_data=0101: busy stays 0, S=R=0 throughout, done pulses in the next cycle.
REQ-035 q_fb stuck at 0000, accept tgt_data=1111: after DRIVE, 8 CHECK mismatches, then err pulses once, done stays 0, and the FSM returns to IDLE.
REQ-036 Assert rst_n=0 during the second DRIVE cycle: S/R drop to 0 immediately with no clock edge; no done or err; a new accept succeeds on the first edge after release.
